// File: rtl/fxp_div_pkg.sv
// Shared types for the streaming fixed-point divider: FSM states, result status, rounding mode.
package fxp_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ROUND = 3'd2,
    S_SIGN  = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_DBZ = 2'b01,
    ST_OVF = 2'b10
  } status_e;

  typedef enum logic {
    RM_TRUNC = 1'b0,
    RM_RNE   = 1'b1
  } rmode_e;

endpackage

// File: rtl/fxp_div_step.sv
// One restoring shift-subtract iteration on magnitudes; purely combinational.
module fxp_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-2:0] acc,
  input  logic [WIDTH-2:0] quo,
  input  logic             din,
  input  logic [WIDTH-2:0] dvs,
  output logic [WIDTH-2:0] acc_nxt,
  output logic [WIDTH-1:0] quo_nxt,
  output logic             qbit
);

  logic [WIDTH-1:0] part;

  // The partial remainder is always below the divisor after a step, so the
  // low WIDTH-1 bits of the subtraction are exact.
  always_comb begin
    part    = {acc, din};
    qbit    = (part >= {1'b0, dvs});
    acc_nxt = qbit ? (part[WIDTH-2:0] - dvs) : part[WIDTH-2:0];
    quo_nxt = {quo, qbit};
  end

endmodule

// File: rtl/fxp_div_stream.sv
// Signed fixed-point divider, one request at a time: WIDTH-1+FBITS+2 cycles per result, 0 for DBZ/input OVF.
// in_ready only in IDLE; results held in OUT until out_ready. FXP_DIV_SAT_EN saturates DBZ/OVF results.
module fxp_div_stream
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  input  logic             in_rmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [TAGW-1:0]  out_tag,
  output logic [1:0]       out_status
);

  localparam int ITER   = WIDTH - 1 + FBITS;
  localparam int CW     = $clog2(ITER + 1);
  localparam int MW     = WIDTH - 1;
  localparam int OVF_SH = WIDTH - 1 - FBITS;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  rmode_e           rmode;
  logic [WIDTH-2:0] a_sh;
  logic [WIDTH-2:0] b_mag;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH-2:0] acc_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             qbit;
  logic [WIDTH-2:0] a_abs;
  logic [WIDTH-2:0] b_abs;
  logic             in_ovf;
  logic             early_ovf;
  logic             rnd_inc;
  logic             sign_ovf;
  logic [WIDTH-1:0] dbz_val;
  logic [WIDTH-1:0] in_ovf_val;
  logic [WIDTH-1:0] run_ovf_val;

  assign in_ready = (state == S_IDLE);

  assign a_abs  = in_a[WIDTH-1] ? (~in_a[WIDTH-2:0] + MW'(1)) : in_a[WIDTH-2:0];
  assign b_abs  = in_b[WIDTH-1] ? (~in_b[WIDTH-2:0] + MW'(1)) : in_b[WIDTH-2:0];
  assign in_ovf = (in_a == MOST_NEG) || (in_b == MOST_NEG);

  fxp_div_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .quo     (quo[WIDTH-2:0]),
    .din     (a_sh[WIDTH-2]),
    .dvs     (b_mag),
    .acc_nxt (acc_nxt),
    .quo_nxt (quo_nxt),
    .qbit    (qbit)
  );

  // After WIDTH-1 steps the leading FBITS quotient bits are final; any set bit
  // means the magnitude cannot fit in WIDTH-1 bits.
  assign early_ovf = (quo_nxt[WIDTH-2:0] >> OVF_SH) != '0;

  // In ROUND the dividend bits are exhausted, so one more step yields the
  // guard bit (qbit) and the sticky remainder (acc_nxt).
  assign rnd_inc  = (rmode == RM_RNE) && qbit && (quo[0] || (acc_nxt != '0));
  assign sign_ovf = quo[WIDTH-1] && !(neg && (quo[WIDTH-2:0] == '0));

`ifdef FXP_DIV_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  assign dbz_val     = (in_a == '0) ? '0 : (in_a[WIDTH-1] ? MOST_NEG : SAT_POS);
  assign in_ovf_val  = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) ? MOST_NEG : SAT_POS;
  assign run_ovf_val = neg ? MOST_NEG : SAT_POS;
`else
  assign dbz_val     = '0;
  assign in_ovf_val  = '0;
  assign run_ovf_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rmode      <= RM_TRUNC;
      a_sh       <= '0;
      b_mag      <= '0;
      acc        <= '0;
      quo        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      out_valid  <= 1'b0;
      out_val    <= '0;
      out_tag    <= '0;
      out_status <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh    <= a_abs;
            b_mag   <= b_abs;
            acc     <= '0;
            quo     <= '0;
            cnt     <= '0;
            neg     <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            rmode   <= rmode_e'(in_rmode);
            out_tag <= in_tag;
            if (in_b == '0) begin
              state      <= S_OUT;
              out_valid  <= 1'b1;
              out_val    <= dbz_val;
              out_status <= ST_DBZ;
            end else if (in_ovf) begin
              state      <= S_OUT;
              out_valid  <= 1'b1;
              out_val    <= in_ovf_val;
              out_status <= ST_OVF;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          a_sh <= a_sh << 1;
          acc  <= acc_nxt;
          quo  <= quo_nxt;
          cnt  <= cnt + CW'(1);
          if ((cnt == CW'(WIDTH - 2)) && early_ovf) begin
            state      <= S_OUT;
            out_valid  <= 1'b1;
            out_val    <= run_ovf_val;
            out_status <= ST_OVF;
          end else if (cnt == CW'(ITER - 1)) begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          quo   <= quo + WIDTH'(rnd_inc);
          state <= S_SIGN;
        end
        S_SIGN: begin
          state     <= S_OUT;
          out_valid <= 1'b1;
          if (sign_ovf) begin
            out_val    <= run_ovf_val;
            out_status <= ST_OVF;
          end else begin
            out_val    <= neg ? (~quo + WIDTH'(1)) : quo;
            out_status <= ST_OK;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fxp_div_stream.md
FXP_DIV_STREAM -- requirements
Module: fxp_div_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: total signed fixed-point width, integer plus fraction.
REQ-002 SHALL have parameter FBITS, default 8: fractional bits within WIDTH; legal range 0..WIDTH-2.
REQ-003 SHALL have parameter TAGW, default 4: width of the pass-through transaction tag.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have ports in_a, in_b  input  WIDTH each  signed dividend and signed divisor.
REQ-009 SHALL have port in_tag  input  TAGW  request tag.
REQ-010 SHALL have port in_rmode  input  1  rounding mode: 0 = truncate toward zero, 1 = round-half-even.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out_val  output  WIDTH  signed quotient.
REQ-014 SHALL have port out_tag  output  TAGW  tag of the request that produced the result.
REQ-015 SHALL have port out_status  output  2  result status: 00 = OK, 01 = DBZ, 10 = OVF.

Function
REQ-016 SHALL implement the FSM states IDLE, CALC, ROUND, SIGN and OUT; in_ready = (state == IDLE).
REQ-017 On in_valid && in_ready, SHALL register |a|, |b| (WIDTH-1 bits each), the sign difference, in_tag and in_rmode.
REQ-018 On acceptance, SHALL initialise the accumulator and quotient registers.
REQ-019 On acceptance with in_b == 0, SHALL go directly to OUT with status DBZ; out_valid rises one cycle after acceptance.
REQ-020 On acceptance with in_a or in_b equal to the most-negative value, SHALL go directly to OUT with status OVF.
REQ-021 CALC SHALL perform one restoring shift-subtract step per cycle, for ITER = WIDTH-1+FBITS cycles, then go to ROUND.
REQ-022 During CALC, if any of the top FBITS quotient bits is non-zero at iteration WIDTH-2, SHALL abort to OUT with status OVF.
REQ-023 ROUND (1 cycle), with rmode = 1: if the next quotient bit is 1 and (the quotient LSB is 1 or the remainder is non-zero), SHALL increment the quotient.
REQ-024 ROUND with rmode = 0: SHALL leave the quotient unchanged.
REQ-025 SIGN (1 cycle) SHALL negate a non-zero quotient when the input signs differ, then go to OUT with status OK; a zero result is never negative.
REQ-026 For non-exception requests, out_valid SHALL rise ITER+2 cycles after the acceptance edge.
REQ-027 In OUT, SHALL hold out_valid, out_val, out_tag and out_status stable until out_ready is high; on out_valid && out_ready, SHALL go to IDLE.
REQ-028 No new request SHALL be accepted in the handshake cycle; the earliest next acceptance is the following cycle.
REQ-029 in_valid, in_a and in_b SHALL be ignored outside IDLE, and in_a/in_b changes after acceptance SHALL not affect the result.

Reset
REQ-030 On rst at a clock edge, including mid-CALC or mid-OUT, SHALL enter IDLE and drop any in-flight transaction.
REQ-031 Reset values SHALL be: out_valid 0, out_val 0, out_tag 0, out_status 00; in_ready is 1 the cycle after reset.

Configuration
REQ-032 Macro FXP_DIV_SAT_EN defined: on OVF, out_val SHALL be 0111..1 if the true result is positive, otherwise 100..0.
REQ-033 Macro FXP_DIV_SAT_EN defined: on DBZ, out_val SHALL be the same saturated value selected by the sign of in_a, or 0 if in_a == 0.
REQ-034 Macro FXP_DIV_SAT_EN undefined: out_val SHALL be 0 for every DBZ or OVF result.

Structure
REQ-035 Package fxp_div_pkg SHALL hold the state enum, the status enum (OK/DBZ/OVF) and the rounding-mode enum.
REQ-036 A sub-module fxp_div_step SHALL hold the combinational one-iteration shift-subtract logic, producing next accumulator and next quotient.

Verification (WIDTH=8, FBITS=4)
REQ-037 a=0x18, b=0x08 (1.5/0.5) -> out_val 0x30, status OK, out_valid rising 13 cycles after acceptance.
REQ-038 a=0xE8, b=0x08 -> out_val 0xD0; a=0x00, b=0xF8 -> out_val 0x00, status OK.
REQ-039 a=0x03, b=0x20: rmode=0 -> 0x01, rmode=1 -> 0x02; a=0x01, b=0x20: both modes -> 0x00.
REQ-040 b=0x00 -> DBZ after 1 cycle; a=0x70, b=0x04 -> OVF, out_val 0x7F with FXP_DIV_SAT_EN, 0x00 without.
REQ-041 out_ready held low 5 cycles in OUT -> outputs stable and in_ready low; tag 0xA returned unchanged.
REQ-042 rst asserted at CALC iteration 3 -> IDLE next cycle, out_valid 0, a new request completes correctly.
